// File: rtl/seq_store.sv
// Sequence store: append entries, then play the whole sequence back over valid/ready.
// Optional SEQ_STORE_PEEK_EN adds a combinational peek port into the storage.
module seq_store #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             append,
    input  logic [WIDTH-1:0] append_data,
    input  logic             play_start,
    input  logic             play_ready,
`ifdef SEQ_STORE_PEEK_EN
    input  logic [AW-1:0]    peek_sel,
    output logic [WIDTH-1:0] peek_data,
`endif
    output logic             play_valid,
    output logic [WIDTH-1:0] play_data,
    output logic             play_last,
    output logic [AW:0]      len,
    output logic             full,
    output logic             busy,
    output logic             drop
);

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t           state_q, state_d;
    logic [AW:0]      len_q, len_d;
    logic [AW:0]      plen_q, plen_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             drop_q, drop_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             app_ok;

    assign full       = (len_q == (AW+1)'(DEPTH));
    assign busy       = (state_q == PLAY);
    assign app_ok     = append & ~full & ~busy;
    assign len        = len_q;
    assign drop       = drop_q;
    assign play_valid = busy;
    assign play_data  = busy ? mem_q[idx_q] : '0;
    assign play_last  = busy && ({1'b0, idx_q} == plen_q - (AW+1)'(1));

`ifdef SEQ_STORE_PEEK_EN
    assign peek_data  = mem_q[peek_sel];
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        plen_d  = plen_q;
        idx_d   = idx_q;
        drop_d  = drop_q;
        mem_d   = mem_q;
        // clr wins over append and play_start; a cleared append is not a drop
        if (clr) begin
            state_d = IDLE;
            len_d   = '0;
            drop_d  = 1'b0;
        end else begin
            if (append && !app_ok) begin
                drop_d = 1'b1;
            end
            if (app_ok) begin
                mem_d[len_q[AW-1:0]] = append_data;
                len_d                = len_q + (AW+1)'(1);
            end
            unique case (state_q)
                IDLE: begin
                    if (play_start && (len_q != '0 || app_ok)) begin
                        state_d = PLAY;
                        idx_d   = '0;
                        plen_d  = len_q + (AW+1)'(app_ok);
                    end
                end
                PLAY: begin
                    if (play_ready) begin
                        if (play_last) begin
                            state_d = IDLE;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            plen_q  <= '0;
            idx_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            plen_q  <= plen_d;
            idx_q   <= idx_d;
            drop_q  <= drop_d;
        end
    end

    // storage is deliberately left out of reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_seq_store.sv
// Bench for seq_store: directed scenarios plus random traffic against a
// sequence-level reference model.
module tb_seq_store;

    localparam int W  = 3;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst, clr, append, play_start, play_ready;
    logic [W-1:0]  append_data;
    logic          play_valid, play_last, full, busy, drop;
    logic [W-1:0]  play_data;
    logic [AW:0]   len;
`ifdef SEQ_STORE_PEEK_EN
    logic [AW-1:0] peek_sel;
    logic [W-1:0]  peek_data;
`endif

    seq_store #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .append     (append),
        .append_data(append_data),
        .play_start (play_start),
        .play_ready (play_ready),
`ifdef SEQ_STORE_PEEK_EN
        .peek_sel   (peek_sel),
        .peek_data  (peek_data),
`endif
        .play_valid (play_valid),
        .play_data  (play_data),
        .play_last  (play_last),
        .len        (len),
        .full       (full),
        .busy       (busy),
        .drop       (drop)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: stored sequence plus playback cursor
    int m_mem [D];
    bit m_wr  [D];
    int m_len;
    bit m_drop;
    bit m_play;
    int m_idx;
    int m_plen;

    task automatic check(string tag, int obs, int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        bit acc;
        if (rst || clr) begin
            if (rst) begin
                m_idx  = 0;
                m_plen = 0;
            end
            m_len  = 0;
            m_drop = 0;
            m_play = 0;
        end else begin
            acc = append && (m_len < D) && !m_play;
            if (append && !acc) m_drop = 1;
            if (m_play) begin
                if (play_ready) begin
                    if (m_idx == m_plen - 1) m_play = 0;
                    else m_idx++;
                end
            end else if (play_start && (m_len > 0 || acc)) begin
                m_play = 1;
                m_idx  = 0;
                m_plen = m_len + int'(acc);
            end
            if (acc) begin
                m_mem[m_len] = int'(append_data);
                m_wr[m_len]  = 1;
                m_len++;
            end
        end
    endtask

    task automatic compare_all();
        check("valid", int'(play_valid), int'(m_play));
        check("data", int'(play_data), m_play ? m_mem[m_idx] : 0);
        check("last", int'(play_last), int'(m_play && m_idx == m_plen - 1));
        check("len", int'(len), m_len);
        check("full", int'(full), int'(m_len == D));
        check("busy", int'(busy), int'(m_play));
        check("drop", int'(drop), int'(m_drop));
`ifdef SEQ_STORE_PEEK_EN
        if (m_wr[peek_sel]) check("peek", int'(peek_data), m_mem[peek_sel]);
`endif
    endtask

    task automatic step(input bit r, input bit c, input bit a,
                        input int d, input bit s, input bit p);
        rst         = r;
        clr         = c;
        append      = a;
        append_data = W'(d);
        play_start  = s;
        play_ready  = p;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < D; i++) begin
            m_mem[i] = 0;
            m_wr[i]  = 0;
        end
        m_len = 0; m_drop = 0; m_play = 0; m_idx = 0; m_plen = 0;
`ifdef SEQ_STORE_PEEK_EN
        peek_sel = '0;
`endif
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 5, 1, 0);
        check("rst_len", int'(len), 0);
        check("rst_valid", int'(play_valid), 0);
        check("rst_data", int'(play_data), 0);
        check("rst_drop", int'(drop), 0);

        // 3,5,1 played back with ready held high
        step(0, 0, 1, 3, 0, 0);
        step(0, 0, 1, 5, 0, 0);
        step(0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        check("seq_d0", int'(play_data), 3);
        step(0, 0, 0, 0, 0, 1);
        check("seq_d1", int'(play_data), 5);
        check("seq_l1", int'(play_last), 0);
        step(0, 0, 0, 0, 0, 1);
        check("seq_d2", int'(play_data), 1);
        check("seq_l2", int'(play_last), 1);
        step(0, 0, 0, 0, 0, 1);
        check("seq_busy", int'(busy), 0);
        check("seq_len", int'(len), 3);

`ifdef SEQ_STORE_PEEK_EN
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0);
        step(0, 0, 1, 7, 0, 0);
        peek_sel = AW'(1);
        #1 check("peek_idle", int'(peek_data), 7);
        step(0, 0, 0, 0, 1, 0);
        check("peek_play", int'(peek_data), 7);
`endif

        // fill to capacity, overflow, then play to the end
        step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < D + 1; i++) step(0, 0, 1, i + 2, 0, 0);
        check("fill_len", int'(len), 16);
        check("fill_drop", int'(drop), 1);
        step(0, 0, 0, 0, 1, 0);
        // stall on entry 0, with an append that must be dropped
        for (int i = 0; i < 4; i++) step(0, 0, i == 2, 1, 0, 0);
        check("stall_d", int'(play_data), 2);
        for (int i = 0; i < D; i++) step(0, 0, 0, 0, 0, 1);
        check("fill_end", int'(busy), 0);

        // append and start in the same cycle on an empty store
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 6, 1, 1);
        check("same_d", int'(play_data), 6);
        check("same_l", int'(play_last), 1);

        // clr then rst mid-playback; later start must be ignored
        step(0, 0, 1, 4, 0, 0);
        step(0, 1, 1, 4, 1, 0);
        step(0, 0, 0, 0, 1, 1);
        check("clr_busy", int'(busy), 0);
        step(0, 0, 1, 2, 0, 0);
        step(0, 0, 1, 3, 1, 0);
        step(1, 0, 1, 3, 1, 1);
        step(0, 0, 0, 0, 1, 0);
        check("rst_play", int'(play_valid), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
`ifdef SEQ_STORE_PEEK_EN
            peek_sel = AW'($urandom_range(D - 1));
`endif
            step($urandom_range(199) == 0, $urandom_range(59) == 0,
                 $urandom_range(9) < 4, int'($urandom_range(7)),
                 $urandom_range(9) == 0, $urandom_range(9) < 7);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
